// File: rtl/ifetch_unit.sv
// Multicycle instruction fetch: owns the PC and assembles a 32-bit little-endian
// instruction from 32/WIDTH memory beats, handing it to decode over valid/ready.
module ifetch_unit #(
  parameter int unsigned      WIDTH    = 8,
  parameter int unsigned      ADRW     = 8,
  parameter logic [ADRW-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADRW-1:0]   mem_adr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [31:0]       instr,
  output logic [ADRW-1:0]   instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADRW-1:0]   redirect_pc,
  output logic [ADRW-1:0]   pc
);

  localparam int unsigned     BEATS = 32 / WIDTH;
  localparam int unsigned     STEP  = WIDTH / 8;
  localparam int unsigned     CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADRW-1:0] INCR  = ADRW'(STEP);
  localparam logic [ADRW-1:0] ALIGN = ~ADRW'(STEP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADRW-1:0]   pc_q, pc_d;
  logic [CW-1:0]     beat_q, beat_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADRW-1:0]   ipc_q, ipc_d;
  logic              beat_done;
  logic              last_beat;

  assign beat_done = (state_q == FETCH) && mem_ack;
  assign last_beat = (beat_q == CW'(BEATS - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect overrides every other event
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        IDLE:    state_d = FETCH;
        FETCH:   if (mem_ack && last_beat) state_d = HOLD;
        HOLD:    if (instr_ready) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from state only, so no input reaches them combinationally
  always_comb begin
    mem_req     = (state_q == FETCH);
    instr_valid = (state_q == HOLD);
  end

  assign mem_adr  = pc_q;
  assign pc       = pc_q;
  assign instr    = instr_q;
  assign instr_pc = ipc_q;

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      beat_q  <= '0;
      instr_q <= '0;
      ipc_q   <= RESET_PC;
    end else begin
      pc_q    <= pc_d;
      beat_q  <= beat_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // A redirect discards any concurrent ack: no byte lane write, no pc step
  always_comb begin
    pc_d    = pc_q;
    beat_d  = beat_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    if (redirect) begin
      pc_d   = redirect_pc & ALIGN;
      beat_d = '0;
    end else if (beat_done) begin
      for (int unsigned k = 0; k < BEATS; k++) begin
        if (beat_q == CW'(k)) begin
          instr_d[k*WIDTH +: WIDTH] = mem_rdata;
        end
      end
      pc_d = pc_q + INCR;
      if (beat_q == '0) begin
        ipc_d = pc_q;
      end
      beat_d = last_beat ? '0 : beat_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: randomized scoreboard run on a byte-wide instance plus
// directed latency, redirect, reset, wrap and beat-order checks on 8/16/32-bit instances.
module tb_ifetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int xfer_cnt = 0;

  logic [7:0] mem [256];

  // Byte-wide instance, randomized memory wait states
  logic        reset, mem_req, mem_ack, instr_valid, instr_ready, redirect;
  logic [7:0]  mem_adr, instr_pc, redirect_pc, pc, mem_rdata;
  logic [31:0] instr;

  ifetch_unit #(.WIDTH(8), .ADRW(8), .RESET_PC(8'h00)) u8 (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_adr(mem_adr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc)
  );

  // Word-wide instance starting near the top of the address space
  logic        r32, req32, ack32, v32, rdy32, rd32;
  logic [7:0]  adr32, ipc32, rpc32, pc32;
  logic [31:0] rdata32, instr32;

  ifetch_unit #(.WIDTH(32), .ADRW(8), .RESET_PC(8'hFC)) u32 (
    .clk(clk), .reset(r32), .mem_req(req32), .mem_adr(adr32),
    .mem_ack(ack32), .mem_rdata(rdata32), .instr(instr32), .instr_pc(ipc32),
    .instr_valid(v32), .instr_ready(rdy32), .redirect(rd32),
    .redirect_pc(rpc32), .pc(pc32)
  );

  // Halfword-wide instance
  logic        r16, req16, ack16, v16, rdy16, rd16;
  logic [7:0]  adr16, ipc16, rpc16, pc16;
  logic [15:0] rdata16;
  logic [31:0] instr16;

  ifetch_unit #(.WIDTH(16), .ADRW(8), .RESET_PC(8'h00)) u16 (
    .clk(clk), .reset(r16), .mem_req(req16), .mem_adr(adr16),
    .mem_ack(ack16), .mem_rdata(rdata16), .instr(instr16), .instr_pc(ipc16),
    .instr_valid(v16), .instr_ready(rdy16), .redirect(rd16),
    .redirect_pc(rpc16), .pc(pc16)
  );

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {mem[b3], mem[b2], mem[b1], mem[a]};
  endfunction

  // Zero-wait memories for the wide instances
  assign ack32   = req32;
  assign rdata32 = word_at(adr32);
  assign ack16   = req16;
  assign rdata16 = {mem[adr16 + 8'd1], mem[adr16]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: the next instruction decode should see
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] word;
  } exp_t;
  exp_t exp_q[$];

  task automatic sb_restart(input logic [7:0] a);
    exp_t e;
    e.pc   = a;
    e.word = word_at(a);
    exp_q.delete();
    exp_q.push_back(e);
  endtask

  // Byte memory model with wait states; also checks the address holds across a beat
  int         wait_mode = 0;
  bit         in_beat   = 0;
  int         wcnt      = 0;
  logic [7:0] beat_adr;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !mem_req) begin
        mem_ack   = 1'b0;
        in_beat   = 1'b0;
        mem_rdata = 8'($urandom);
      end else begin
        if (mem_ack || redirect) in_beat = 1'b0;
        if (!in_beat) begin
          in_beat  = 1'b1;
          beat_adr = mem_adr;
          wcnt     = (wait_mode < 0) ? int'($urandom_range(2)) : wait_mode;
        end else begin
          chk("mem_adr_stable", mem_adr, beat_adr);
        end
        if (wcnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_adr];
        end else begin
          mem_ack   = 1'b0;
          wcnt--;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks HOLD invariants
  exp_t        mon_e;
  logic [7:0]  mon_na;
  logic        prev_stay = 1'b0;
  logic [31:0] prev_instr;
  logic [7:0]  prev_ipc;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stay = 1'b0;
      end else begin
        chk("req_valid_exclusive", mem_req & instr_valid, 1'b0);
        if (prev_stay) begin
          chk("hold_valid", instr_valid, 1'b1);
          chk("hold_instr", instr, prev_instr);
          chk("hold_instr_pc", instr_pc, prev_ipc);
        end
        if (instr_valid) begin
          mon_na = instr_pc + 8'd4;
          chk("hold_pc", pc, mon_na);
        end
        if (instr_valid && instr_ready && !redirect) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got instr 0x%08h at 0x%02h, expected none", instr, instr_pc);
          end else begin
            mon_e = exp_q.pop_front();
            chk("sb_instr", instr, mon_e.word);
            chk("sb_instr_pc", instr_pc, mon_e.pc);
            mon_na = mon_e.pc + 8'd4;
            exp_q.push_back('{mon_na, word_at(mon_na)});
          end
        end
        prev_stay  = instr_valid && !instr_ready && !redirect;
        prev_instr = instr;
        prev_ipc   = instr_pc;
      end
    end
  end

  task automatic release8();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    sb_restart(8'h00);
  endtask

  task automatic do_reset8();
    reset       = 1'b1;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    exp_q.delete();
    release8();
  endtask

  // Counts edges until the byte instance shows instr_valid; 0 means the bound expired
  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  int         n, x0, xs;
  logic [7:0] ea;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20; mem[1] = 8'h10; mem[2] = 8'h00; mem[3] = 8'h80;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    r32 = 1'b1; rd32 = 1'b0; rpc32 = '0; rdy32 = 1'b0;
    r16 = 1'b1; rd16 = 1'b0; rpc16 = '0; rdy16 = 1'b0;
    #1;
    chk("reset_req", mem_req, 1'b0);
    chk("reset_valid", instr_valid, 1'b0);
    chk("reset_pc", pc, 8'h00);
    chk("reset_instr", instr, 32'h0);

    // Zero-wait first fetch after reset
    wait_mode = 0;
    do_reset8();
    instr_ready = 1'b1;
    wait_valid(20, n);
    chk("t1_latency", n, 5);
    chk("t1_instr", instr, 32'h80001020);
    chk("t1_instr_pc", instr_pc, 8'h00);
    chk("t1_pc", pc, 8'h04);
    @(negedge clk);
    chk("t1_next_req", mem_req, 1'b1);
    chk("t1_next_adr", mem_adr, 8'h04);

    // Two wait states per beat
    wait_mode = 2;
    do_reset8();
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (instr_valid) begin
        n = i;
        break;
      end
      if (i <= 12) chk("t2_adr", mem_adr, (i - 1) / 3);
    end
    chk("t2_latency", n, 13);
    chk("t2_instr", instr, 32'h80001020);

    // Backpressure in HOLD
    repeat (4) begin
      @(negedge clk);
      chk("t3_valid", instr_valid, 1'b1);
      chk("t3_req", mem_req, 1'b0);
      chk("t3_instr", instr, 32'h80001020);
      chk("t3_instr_pc", instr_pc, 8'h00);
    end
    @(posedge clk); #2;
    instr_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_resume_req", mem_req, 1'b1);
    chk("t3_resume_adr", mem_adr, 8'h04);

    // Mid-fetch redirect with a concurrent ack
    wait_mode = 0;
    @(posedge clk); #2;
    instr_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 8'h10;
    sb_restart(8'h10);
    @(posedge clk); #2;
    redirect = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    redirect = 1'b1; redirect_pc = 8'h43;
    sb_restart(8'h43);
    @(negedge clk);
    chk("t4_adr_beat2", mem_adr, 8'h12);
    chk("t4_concurrent_ack", mem_ack, 1'b1);
    @(posedge clk); #2;
    redirect = 1'b0;
    @(negedge clk);
    chk("t4_redirect_adr", mem_adr, 8'h43);
    chk("t4_redirect_pc", pc, 8'h43);
    wait_valid(20, n);
    chk("t4_seen", n != 0, 1'b1);
    chk("t4_instr_pc", instr_pc, 8'h43);
    chk("t4_instr", instr, word_at(8'h43));

    // Redirect in HOLD together with instr_ready
    @(posedge clk); #2;
    instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 8'h80;
    sb_restart(8'h80);
    x0 = xfer_cnt;
    @(negedge clk);
    chk("t5_hold_valid", instr_valid, 1'b1);
    @(posedge clk); #2;
    redirect = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    chk("t5_no_xfer", xfer_cnt, x0);
    chk("t5_valid", instr_valid, 1'b0);
    chk("t5_req", mem_req, 1'b1);
    chk("t5_pc", pc, 8'h80);

    // Asynchronous reset mid-beat
    wait_mode = 2;
    @(posedge clk); #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_rst_req", mem_req, 1'b0);
    chk("t5_rst_valid", instr_valid, 1'b0);
    chk("t5_rst_pc", pc, 8'h00);
    chk("t5_rst_instr_pc", instr_pc, 8'h00);
    chk("t5_rst_instr", instr, 32'h0);
    release8();

    // Randomized traffic
    wait_mode = -1;
    xs = xfer_cnt;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      instr_ready = ($urandom_range(3) != 0);
      if ($urandom_range(23) == 0) begin
        redirect    = 1'b1;
        redirect_pc = 8'($urandom);
        sb_restart(redirect_pc);
      end else begin
        redirect = 1'b0;
      end
    end
    @(posedge clk); #2;
    redirect = 1'b0; instr_ready = 1'b1; wait_mode = 0;
    x0 = xfer_cnt;
    for (int c = 0; c < 40 && xfer_cnt < x0 + 2; c++) @(negedge clk);
    chk("drain_xfers", xfer_cnt >= x0 + 2, 1'b1);
    chk("rand_progress", xfer_cnt > xs + 100, 1'b1);

    // Word-wide instance: one beat per instruction, pc wraps past 0xFC
    rdy32 = 1'b1;
    @(posedge clk); #2;
    r32 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("w32_valid_slot", v32, (i % 2) == 0);
      if (v32) begin
        ea = 8'hFC + 8'(4 * (i / 2 - 1));
        chk("w32_instr_pc", ipc32, ea);
        chk("w32_instr", instr32, word_at(ea));
      end
      if (i == 2) chk("w32_wrap_pc", pc32, 8'h00);
    end
    @(posedge clk); #2;
    rd32 = 1'b1; rpc32 = 8'h43;
    @(posedge clk); #2;
    rd32 = 1'b0;
    @(negedge clk);
    chk("w32_align_adr", adr32, 8'h40);
    chk("w32_align_req", req32, 1'b1);

    // Halfword instance: low half from 0x00, high half from 0x02
    @(posedge clk); #2;
    r16 = 1'b0;
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) chk("w16_adr_beat0", adr16, 8'h00);
      if (i == 2) chk("w16_adr_beat1", adr16, 8'h02);
      if (v16) begin
        n = i;
        break;
      end
    end
    chk("w16_latency", n, 3);
    chk("w16_instr", instr16, 32'h80001020);
    chk("w16_instr_pc", ipc16, 8'h00);
    chk("w16_pc", pc16, 8'h04);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
